// File: rtl/multicycle_controller.sv
// Multi-cycle control unit for an RV32I core with optional M extension.
// Sequences each instruction through FETCH/DECODE/EXEC/MEMORY/WRITEBACK. Handshakes with
// the instruction memory, the data memory and a multi-cycle ALU. Illegal words park it in TRAP.
module multicycle_controller #(
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned OP_W     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            alu_done,
  input  logic            br_taken,
  output logic            imem_req,
  output logic            ir_we,
  output logic            pc_we,
  output logic            pc_src,
  output logic            sela,
  output logic            selb,
  output logic [OP_W-1:0] op,
  output logic [2:0]      op_b,
  output logic            alu_start,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            we,
  output logic [1:0]      wb_sel,
  output logic            illegal,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExec      = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  // RV32I major opcodes
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcFence  = 7'b0001111;

  // ALU opcodes
  localparam logic [OP_W-1:0] OpAdd = OP_W'(1);
  localparam logic [OP_W-1:0] OpSub = OP_W'(2);
  localparam logic [OP_W-1:0] OpSll = OP_W'(3);
  localparam logic [OP_W-1:0] OpSrl = OP_W'(4);
  localparam logic [OP_W-1:0] OpSra = OP_W'(5);
  localparam logic [OP_W-1:0] OpSlu = OP_W'(6);
  localparam logic [OP_W-1:0] OpSlt = OP_W'(7);
  localparam logic [OP_W-1:0] OpOr  = OP_W'(8);
  localparam logic [OP_W-1:0] OpAnd = OP_W'(9);
  localparam logic [OP_W-1:0] OpXor = OP_W'(10);
  localparam logic [OP_W-1:0] OpSiu = OP_W'(11);
  localparam logic [OP_W-1:0] OpAiu = OP_W'(12);
  localparam logic [OP_W-1:0] OpMul = OP_W'(13);

  // Branch-logic opcodes
  localparam logic [2:0] BrZer = 3'd1;
  localparam logic [2:0] BrNzr = 3'd2;
  localparam logic [2:0] BrJmp = 3'd5;

  // Writeback sources
  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMem = 2'd1;
  localparam logic [1:0] WbPc4 = 2'd2;

  state_e state_q, state_d;

  logic [31:0] ir_q;
  logic [6:0]  opc;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        unused_ir;

  // Decoded (combinational) view of the latched word
  logic [OP_W-1:0] d_op;
  logic [2:0]      d_op_b;
  logic            d_sela, d_selb;
  logic [1:0]      d_wb_sel;
  logic            d_branch, d_jump, d_load, d_store, d_mop, d_fence, d_illegal;

  // Registered decode results, stable from DECODE until the next DECODE
  logic [OP_W-1:0] op_q;
  logic [2:0]      op_b_q;
  logic            sela_q, selb_q;
  logic [1:0]      wb_sel_q;
  logic            branch_q, jump_q, load_q, store_q, mop_q, fence_q;

  // Set once the ALU start pulse has been issued for the current M op
  logic alu_busy_q;

  assign opc       = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

  function automatic logic [OP_W-1:0] alu_op(input logic [2:0] fn3, input logic alt);
    logic [OP_W-1:0] res;
    case (fn3)
      3'b000:  res = alt ? OpSub : OpAdd;
      3'b001:  res = OpSll;
      3'b010:  res = OpSlt;
      3'b011:  res = OpSlu;
      3'b100:  res = OpXor;
      3'b101:  res = alt ? OpSra : OpSrl;
      3'b110:  res = OpOr;
      default: res = OpAnd;
    endcase
    return res;
  endfunction

  // Instruction register: loaded on the accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else if (state_q == StFetch && imem_ready) begin
      ir_q <= instr;
    end
  end

  // Instruction decode of the latched word
  always_comb begin
    d_op      = '0;
    d_op_b    = '0;
    d_sela    = 1'b0;
    d_selb    = 1'b0;
    d_wb_sel  = WbAlu;
    d_branch  = 1'b0;
    d_jump    = 1'b0;
    d_load    = 1'b0;
    d_store   = 1'b0;
    d_mop     = 1'b0;
    d_fence   = 1'b0;
    d_illegal = 1'b0;
    case (opc)
      OpcReg: begin
        d_sela = 1'b1;
        d_selb = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (ENABLE_M) begin
            d_mop = 1'b1;
            d_op  = OpMul + OP_W'(funct3);
          end else begin
            d_illegal = 1'b1;
          end
        end else if (funct7 == 7'b0000000) begin
          d_op = alu_op(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          d_op = alu_op(funct3, 1'b1);
        end else begin
          d_illegal = 1'b1;
        end
      end
      OpcImm: begin
        d_sela = 1'b1;
        // Only the shift forms constrain the upper bits; elsewhere they are immediate
        if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
          d_illegal = 1'b1;
        end else if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          d_illegal = 1'b1;
        end else begin
          d_op = alu_op(funct3, funct3 == 3'b101 && funct7[5]);
        end
      end
      OpcLoad: begin
        d_sela   = 1'b1;
        d_op     = OpAdd;
        d_wb_sel = WbMem;
        d_load   = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
          d_illegal = 1'b1;
        end
      end
      OpcStore: begin
        d_sela  = 1'b1;
        d_op    = OpAdd;
        d_store = 1'b1;
        if (funct3[2] || funct3 == 3'b011) begin
          d_illegal = 1'b1;
        end
      end
      OpcBranch: begin
        d_sela   = 1'b1;
        d_selb   = 1'b1;
        d_branch = 1'b1;
        // Equality via subtract-and-test-zero; ordering via set-less-than result
        case (funct3)
          3'b000:  begin d_op = OpSub; d_op_b = BrZer; end
          3'b001:  begin d_op = OpSub; d_op_b = BrNzr; end
          3'b100:  begin d_op = OpSlt; d_op_b = BrNzr; end
          3'b101:  begin d_op = OpSlt; d_op_b = BrZer; end
          3'b110:  begin d_op = OpSlu; d_op_b = BrNzr; end
          3'b111:  begin d_op = OpSlu; d_op_b = BrZer; end
          default: d_illegal = 1'b1;
        endcase
      end
      OpcJal: begin
        d_op     = OpAdd;
        d_op_b   = BrJmp;
        d_wb_sel = WbPc4;
        d_jump   = 1'b1;
      end
      OpcJalr: begin
        d_sela   = 1'b1;
        d_op     = OpAdd;
        d_op_b   = BrJmp;
        d_wb_sel = WbPc4;
        d_jump   = 1'b1;
        if (funct3 != 3'b000) begin
          d_illegal = 1'b1;
        end
      end
      OpcLui: begin
        d_op = OpSiu;
      end
      OpcAuipc: begin
        d_op = OpAiu;
      end
      OpcFence: begin
        d_fence = 1'b1;
      end
      default: begin
        // Includes SYSTEM, which this core does not implement
        d_illegal = 1'b1;
      end
    endcase
  end

  // Decode register: captured in DECODE only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      op_b_q   <= '0;
      sela_q   <= 1'b0;
      selb_q   <= 1'b0;
      wb_sel_q <= WbAlu;
      branch_q <= 1'b0;
      jump_q   <= 1'b0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      mop_q    <= 1'b0;
      fence_q  <= 1'b0;
    end else if (state_q == StDecode) begin
      op_q     <= d_op;
      op_b_q   <= d_op_b;
      sela_q   <= d_sela;
      selb_q   <= d_selb;
      wb_sel_q <= d_wb_sel;
      branch_q <= d_branch;
      jump_q   <= d_jump;
      load_q   <= d_load;
      store_q  <= d_store;
      mop_q    <= d_mop;
      fence_q  <= d_fence;
    end
  end

  // ALU-busy flag: low in the first EXEC cycle so the start pulse fires exactly once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_busy_q <= 1'b0;
    end else begin
      alu_busy_q <= (state_q == StExec) && mop_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (imem_ready) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = d_illegal ? StTrap : StExec;
      end
      StExec: begin
        if (mop_q) begin
          // A done coinciding with the start pulse belongs to nothing we issued
          if (alu_busy_q && alu_done) begin
            state_d = StWriteback;
          end
        end else if (branch_q) begin
          state_d = StFetch;
        end else if (load_q || store_q) begin
          state_d = StMemory;
        end else begin
          state_d = StWriteback;
        end
      end
      StMemory: begin
        if (dmem_ready) begin
          state_d = store_q ? StFetch : StWriteback;
        end
      end
      StWriteback: begin
        state_d = StFetch;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Output logic: strobes are decoded from the state register so reset clears them at once
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_start = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    we        = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        // Gated by reset so the request stays low while reset is held
        imem_req = rst_n;
        ir_we    = rst_n & imem_ready;
      end
      StExec: begin
        if (mop_q) begin
          alu_start = ~alu_busy_q;
        end else if (branch_q) begin
          pc_we  = 1'b1;
          pc_src = br_taken;
        end else if (jump_q) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end
      end
      StMemory: begin
        dmem_req = 1'b1;
        dmem_we  = store_q;
        pc_we    = store_q & dmem_ready;
      end
      StWriteback: begin
        we    = ~fence_q;
        pc_we = ~jump_q;
      end
      StTrap: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign op     = op_q;
  assign op_b   = op_b_q;
  assign sela   = sela_q;
  assign selb   = selb_q;
  assign wb_sel = wb_sel_q;
  assign state  = state_q;

endmodule
